// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// FSM encoding, operation select values and default width.
package div_pkg;

  localparam int DIV_WIDTH_DEF = 32;

  localparam logic DIV_OP_QUO = 1'b1;
  localparam logic DIV_OP_REM = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division step.
// Shift in the next dividend bit, compare, subtract.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] dv;
  logic [WIDTH:0] df;
  logic           qb;
  logic           unused_msb;

  // Partial remainder stays below the divisor, so its MSB is always 0.
  assign unused_msb = rem_i[WIDTH];

  assign sh    = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
  assign dv    = {1'b0, dvs_i};
  assign df    = sh - dv;
  assign qb    = (sh >= dv);
  assign rem_o = qb ? df : sh;
  assign quo_o = {quo_i[WIDTH-2:0], qb};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider with tag, flush and
// valid/ready result handshake.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH  = DIV_WIDTH_DEF,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_en_in,
  output logic              div_ready,
  input  logic              div_op,
  input  logic              div_sign,
  input  logic [WIDTH-1:0]  div_sr0,
  input  logic [WIDTH-1:0]  div_sr1,
  input  logic [ADDR_W-1:0] div_addr_in,
  input  logic              div_flush,
  output logic              div_en_out,
  input  logic              div_out_ready,
  output logic [WIDTH-1:0]  div_result,
  output logic [ADDR_W-1:0] div_addr_out,
  output logic              div_dbz,
  output logic              stall_because_div
);

  localparam int CW = $clog2(WIDTH);

  div_state_e state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH:0]    rem_q, rem_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [WIDTH-1:0]  dvd_q, dvd_d;
  logic              op_q, op_d;
  logic              sign_q, sign_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              zero_q, zero_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dbzo_q, dbzo_d;

  logic [WIDTH:0]   rem_s;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] mag0;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] qfix;
  logic [WIDTH-1:0] rfix;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .dvs_i(dvs_q),
    .rem_o(rem_s),
    .quo_o(quo_s)
  );

  assign mag0 = (sign_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
  assign mag1 = (sign_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;

  // Divide-by-zero results are passed through unsigned-corrected.
  assign qfix = (qneg_q && !zero_q) ? -quo_q : quo_q;
  assign rfix = (rneg_q && !zero_q) ? -rem_q[WIDTH-1:0]
                                    : rem_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    op_d    = op_q;
    sign_d  = sign_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    tag_d   = tag_q;
    res_d   = res_q;
    addr_d  = addr_q;
    dbzo_d  = dbzo_q;
    unique case (state_q)
      S_IDLE: begin
        if (div_en_in) begin
          op_d    = div_op;
          sign_d  = div_sign;
          dvd_d   = div_sr0;
          dvs_d   = div_sr1;
          tag_d   = div_addr_in;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        qneg_d = sign_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
        rneg_d = sign_q & dvd_q[WIDTH-1];
        rem_d  = '0;
        cnt_d  = CW'(WIDTH - 1);
        zero_d = (dvs_q == '0);
        if (zero_d) begin
          quo_d   = '1;
          rem_d   = {1'b0, dvd_q};
          state_d = S_FIX;
        end else begin
          quo_d   = mag0;
          dvs_d   = mag1;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        rem_d = rem_s;
        quo_d = quo_s;
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        res_d   = (op_q == DIV_OP_QUO) ? qfix : rfix;
        addr_d  = tag_q;
        dbzo_d  = zero_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (div_out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush beats every transition, including the DONE handshake.
    if (div_flush) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      op_q    <= 1'b0;
      sign_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      tag_q   <= '0;
      res_q   <= '0;
      addr_q  <= '0;
      dbzo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      addr_q  <= addr_d;
      dbzo_q  <= dbzo_d;
    end
  end

  assign div_ready         = (state_q == S_IDLE);
  assign stall_because_div = (state_q != S_IDLE);
  assign div_en_out        = (state_q == S_DONE);
  assign div_result        = res_q;
  assign div_addr_out      = addr_q;
  assign div_dbz           = dbzo_q;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed table, corner sequences and
// randomized ops against an arithmetic reference model.
module tb_div_seq;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          div_en_in;
  logic          div_ready;
  logic          div_op;
  logic          div_sign;
  logic [W-1:0]  div_sr0;
  logic [W-1:0]  div_sr1;
  logic [AW-1:0] div_addr_in;
  logic          div_flush;
  logic          div_en_out;
  logic          div_out_ready;
  logic [W-1:0]  div_result;
  logic [AW-1:0] div_addr_out;
  logic          div_dbz;
  logic          stall_because_div;

  int n_tests = 0;
  int n_fail  = 0;

  div_seq #(
    .WIDTH(W),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .div_en_in(div_en_in),
    .div_ready(div_ready),
    .div_op(div_op),
    .div_sign(div_sign),
    .div_sr0(div_sr0),
    .div_sr1(div_sr1),
    .div_addr_in(div_addr_in),
    .div_flush(div_flush),
    .div_en_out(div_en_out),
    .div_out_ready(div_out_ready),
    .div_result(div_result),
    .div_addr_out(div_addr_out),
    .div_dbz(div_dbz),
    .stall_because_div(stall_because_div)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         op;
    logic         sign;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [4:0]   tag;
    int           hold;
    logic [31:0]  res;
    logic         dbz;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference: plain 64-bit arithmetic; % truncates toward zero.
  function automatic logic [32:0] model(input logic op, input logic sign,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return {1'b1, op ? 32'hFFFF_FFFF : a};
    sa = sign ? {{32{a[31]}}, a} : {32'b0, a};
    sb = sign ? {{32{b[31]}}, b} : {32'b0, b};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, op ? q[31:0] : r[31:0]};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_op(input logic op, input logic sign,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input int hold,
                       input logic [32:0] expv);
    int edges;
    logic [31:0] r0;
    @(negedge clk);
    check("ready_before", div_ready, 1);
    div_en_in   = 1'b1;
    div_op      = op;
    div_sign    = sign;
    div_sr0     = a;
    div_sr1     = b;
    div_addr_in = tag;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    div_en_in   = 1'b0;
    div_sr0     = $urandom;
    div_sr1     = $urandom;
    div_addr_in = 5'($urandom);
    while (!div_en_out && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("latency", edges, (b == 0) ? 3 : W + 3);
    check("result", div_result, expv[31:0]);
    check("addr", div_addr_out, tag);
    check("dbz", div_dbz, expv[32]);
    r0 = div_result;
    for (int i = 0; i < hold; i++) begin
      div_en_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", div_en_out, 1);
      check("hold_result", div_result, r0);
      check("hold_addr", div_addr_out, tag);
      check("hold_ready", div_ready, 0);
      check("hold_stall", stall_because_div, 1);
    end
    div_en_in     = 1'b0;
    div_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_out_ready = 1'b0;
    check("post_valid", div_en_out, 0);
    check("post_ready", div_ready, 1);
    if (edges >= 100) do_reset();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic [31:0] a, b;
    logic op, sign;

    tbl[0]  = '{1'b1, 1'b0, 32'd100, 32'd7, 5'd3, 0, 32'd14, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'd100, 32'd7, 5'd3, 0, 32'd2, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd4, 0,
                32'hFFFF_FFFD, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd5, 0,
                32'hFFFF_FFFF, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0,
                32'h8000_0000, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0,
                32'h0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 32'h1234, 32'h0, 5'd9, 0,
                32'hFFFF_FFFF, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 32'h1234, 32'h0, 5'd10, 0,
                32'h1234, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 32'hDEAD_BEEF, 32'd1, 5'd11, 5,
                32'hDEAD_BEEF, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 32'hFFFF_FFFB, 32'h0, 5'd12, 0,
                32'hFFFF_FFFB, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 32'd100, 32'hFFFF_FFF9, 5'd13, 0,
                32'hFFFF_FFF2, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 5'd14, 0,
                32'd2, 1'b0};

    rst           = 1'b1;
    div_en_in     = 1'b0;
    div_op        = 1'b0;
    div_sign      = 1'b0;
    div_sr0       = '0;
    div_sr1       = '0;
    div_addr_in   = '0;
    div_flush     = 1'b0;
    div_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", div_en_out, 0);
    check("rst_result", div_result, 0);
    check("rst_addr", div_addr_out, 0);
    check("rst_dbz", div_dbz, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rel_ready", div_ready, 1);
    check("rel_stall", stall_because_div, 0);

    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].op, tbl[i].sign, tbl[i].a, tbl[i].b, tbl[i].tag,
            tbl[i].hold, {tbl[i].dbz, tbl[i].res});
    end

    // Flush partway through the iterations.
    @(negedge clk);
    div_en_in = 1'b1;
    div_op    = 1'b1;
    div_sign  = 1'b0;
    div_sr0   = 32'd100;
    div_sr1   = 32'd7;
    @(posedge clk);
    @(negedge clk);
    div_en_in = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("flush_busy", stall_because_div, 1);
    div_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_flush = 1'b0;
    check("flush_ready", div_ready, 1);
    check("flush_stall", stall_because_div, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= div_en_out;
    end
    check("flush_no_valid", seen, 0);
    do_op(1'b1, 1'b0, 32'd1000, 32'd9, 5'd7, 0,
          model(1'b1, 1'b0, 32'd1000, 32'd9));

    // Reset in the middle of an operation.
    @(negedge clk);
    div_en_in   = 1'b1;
    div_op      = 1'b0;
    div_sr0     = 32'd12345;
    div_sr1     = 32'd17;
    div_addr_in = 5'd21;
    @(posedge clk);
    @(negedge clk);
    div_en_in = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", div_en_out, 0);
    check("mid_rst_result", div_result, 0);
    check("mid_rst_addr", div_addr_out, 0);
    check("mid_rst_dbz", div_dbz, 0);
    check("mid_rst_stall", stall_because_div, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rel_ready", div_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= div_en_out;
    end
    check("mid_rst_no_valid", seen, 0);

    for (int i = 0; i < 40; i++) begin
      a    = $urandom;
      op   = 1'($urandom_range(0, 1));
      sign = 1'($urandom_range(0, 1));
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom_range(1, 15);
        2: b = (i % 8 == 2) ? 32'h0 : $urandom_range(1, 1000);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (i % 10 == 5) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      do_op(op, sign, a, b, 5'($urandom), $urandom_range(0, 2),
            model(op, sign, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
